mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, meaning stall cycles per data-memory access (legal 1..15).
REQ-002 SHALL have parameter MEM_DEPTH, default 64, meaning number of 32-bit data-memory words (power of two).
REQ-003 SHALL have port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports MEMMemRead / MEMMemWrite  input  1 each  load / store request from EX_MEM.
REQ-006 SHALL have ports MEMRegWrite / MEMMemtoReg  input  1 each  writeback controls from EX_MEM.
REQ-007 SHALL have port MEMALUResult  input  32  byte address for memory ops, or the result for non-memory ops.
REQ-008 SHALL have port MEMWriteData  input  32  store data.
REQ-009 SHALL have port MEMRegisterRd  input  5  destination register.
REQ-010 SHALL have ports OutRegWrite / OutMemtoReg  output  1 each  controls to MEM_WB.
REQ-011 SHALL have ports OutMemData / OutALUResult  output  32 each  load data / ALU result to MEM_WB.
REQ-012 SHALL have port OutRegisterRd  output  5  destination register to MEM_WB.
REQ-013 SHALL have port MemStall  output  1  high tells EX_MEM and upstream stages to hold.
REQ-014 SHALL have port MemError  output  1  one-cycle pulse on a misaligned access.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and DONE, plus a 4-bit down-counter.
REQ-016 In IDLE with neither MEMMemRead nor MEMMemWrite, SHALL pass MEMRegWrite, MEMMemtoReg, MEMALUResult and MEMRegisterRd combinationally to the Out* ports, with MemStall=0.
REQ-017 In IDLE with MEMMemRead or MEMMemWrite and MEMALUResult[1:0]==0, SHALL assert MemStall, load counter=MEM_LATENCY-1 and go to WAIT.
REQ-018 In WAIT, SHALL hold MemStall=1 and OutRegWrite=0 (bubble to MEM_WB), and decrement the counter each cycle.
REQ-019 On the edge leaving WAIT with counter==0, SHALL go to DONE and perform the access at that edge.
REQ-020 For a store, the access SHALL write MEMWriteData to word MEMALUResult[log2(MEM_DEPTH)+1:2].
REQ-021 For a load, the access SHALL latch that word into the OutMemData register.
REQ-022 Each access SHALL therefore occupy the stage for MEM_LATENCY+1 cycles: MEM_LATENCY stall cycles, then one DONE cycle.
REQ-023 In DONE, SHALL drive MemStall=0, pass OutRegWrite=MEMRegWrite, and pass the other Out* fields from the held EX_MEM inputs.
REQ-024 SHALL return from DONE to IDLE at the next edge; the next instruction is evaluated in IDLE.
REQ-025 When a load and a store are both asserted, SHALL treat the access as a load and perform no write.
REQ-026 A misaligned access (MEMALUResult[1:0]!=0 with a read or write in IDLE) SHALL perform no memory access, pulse MemError for that cycle, force OutRegWrite=0, keep MemStall=0 and stay in IDLE.
REQ-027 Address bits above the index SHALL be ignored, so the word index wraps modulo MEM_DEPTH.
REQ-028 OutMemData SHALL change only on a load completion or on reset.
REQ-029 A store immediately followed by a load to the same word SHALL return the new data.

Reset
REQ-030 While Rst_n=0, state SHALL be IDLE, the counter 0, OutMemData 0, and MemStall, MemError and OutRegWrite 0.
REQ-031 Reset SHALL take effect immediately and independently of Clk.
REQ-032 Reset asserted during WAIT SHALL abort the access: no memory write and no OutMemData update.
REQ-033 Memory contents SHALL NOT be cleared by reset; simulation initialises them to 0.
REQ-034 After Rst_n rises, the first rising edge SHALL evaluate inputs in IDLE.

Verification
REQ-035 SHALL cover: MEM_LATENCY=2, store 0xDEADBEEF to addr 0x10 -> MemStall high 2 cycles, DONE cycle with OutRegWrite=0; word 4 then holds 0xDEADBEEF.
REQ-036 SHALL cover: load from 0x10 with MEMRegWrite=1, MEMMemtoReg=1, Rd=5 -> 2 stall cycles with OutRegWrite=0, then DONE with OutMemData=0xDEADBEEF, OutRegWrite=1, OutRegisterRd=5.
REQ-037 SHALL cover: ALU op with result 0x1234 and Rd=3 in IDLE -> same cycle OutALUResult=0x1234, OutRegisterRd=3, MemStall=0.
REQ-038 SHALL cover: load at 0x13 -> MemError=1 for one cycle, OutRegWrite=0, no stall, OutMemData unchanged.
REQ-039 SHALL cover: store 0x5 to 0x20 with Rst_n pulsed low during the first WAIT cycle -> MemStall drops immediately, word 8 unchanged, FSM in IDLE.
REQ-040 SHALL cover: store to 0x100 with MEM_DEPTH=64 -> writes word 0; a following load from 0x0 returns the stored value.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: multi-cycle data-memory access with stall handshake.
// Loads latch into OutMemData; stores write the internal word array.
module mem_stage #(
    parameter int MEM_LATENCY = 2,
    parameter int MEM_DEPTH   = 64
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        MEMMemRead,
    input  logic        MEMMemWrite,
    input  logic        MEMRegWrite,
    input  logic        MEMMemtoReg,
    input  logic [31:0] MEMALUResult,
    input  logic [31:0] MEMWriteData,
    input  logic [4:0]  MEMRegisterRd,
    output logic        OutRegWrite,
    output logic        OutMemtoReg,
    output logic [31:0] OutMemData,
    output logic [31:0] OutALUResult,
    output logic [4:0]  OutRegisterRd,
    output logic        MemStall,
    output logic        MemError
);

    localparam int IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t state, nextState;
    logic [3:0] count, nextCount;
    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] memDataQ;
    logic [IdxW-1:0] wordIdx;
    logic memReq;
    logic misaligned;
    logic accessNow;
    logic stall;
    logic err;
    logic regWr;
    logic doLoad;
    logic doStore;

    assign memReq     = MEMMemRead | MEMMemWrite;
    assign misaligned = (MEMALUResult[1:0] != 2'b00);
    assign wordIdx    = MEMALUResult[IdxW+1:2];

    // The accepting IDLE cycle is the first stall cycle, so WAIT
    // covers the remaining MEM_LATENCY-1 and is skipped at latency 1.
    always_comb begin
        nextState = state;
        nextCount = count;
        accessNow = 1'b0;
        stall     = 1'b0;
        err       = 1'b0;
        regWr     = 1'b0;
        unique case (state)
            IDLE: begin
                if (memReq && misaligned) begin
                    err = 1'b1;
                end else if (memReq) begin
                    stall = 1'b1;
                    if (MEM_LATENCY <= 1) begin
                        accessNow = 1'b1;
                        nextState = DONE;
                    end else begin
                        nextCount = 4'(MEM_LATENCY - 1);
                        nextState = WAIT;
                    end
                end else begin
                    regWr = MEMRegWrite;
                end
            end
            WAIT: begin
                stall     = 1'b1;
                nextCount = count - 4'd1;
                if (count <= 4'd1) begin
                    accessNow = 1'b1;
                    nextCount = 4'd0;
                    nextState = DONE;
                end
            end
            DONE: begin
                regWr     = MEMRegWrite;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
                nextCount = 4'd0;
            end
        endcase
    end

    assign doLoad  = Rst_n & accessNow & MEMMemRead;
    assign doStore = Rst_n & accessNow & MEMMemWrite & ~MEMMemRead;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            count    <= 4'd0;
            memDataQ <= 32'd0;
        end else begin
            state <= nextState;
            count <= nextCount;
            if (doLoad) begin
                memDataQ <= mem[wordIdx];
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge Clk) begin
        if (doStore) begin
            mem[wordIdx] <= MEMWriteData;
        end
    end

    assign MemStall      = Rst_n & stall;
    assign MemError      = Rst_n & err;
    assign OutRegWrite   = Rst_n & regWr;
    assign OutMemtoReg   = MEMMemtoReg;
    assign OutALUResult  = MEMALUResult;
    assign OutRegisterRd = MEMRegisterRd;
    assign OutMemData    = memDataQ;

endmodule
